pix_clken_gen: RTL



---
 rtl/pix_clken_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pix_clken_gen.sv
// Fractional clock-enable generator with PLL lock supervisor.
// Filters pll_lock, holds downstream in reset until lock is stable, then emits num/den strobes per channel.
module pix_clken_gen #(
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = 16,
  parameter int LOCK_FILT = 1024,
  parameter int DEF_NUM   = 1,
  parameter int DEF_DEN   = 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_num,
  input  logic [ACC_W-1:0]  cfg_den,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked,
  output logic              rst_out
);

  localparam int CNT_W = $clog2(LOCK_FILT);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic              sync1_q;
  logic              sync2_q;
  logic              lock_s;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_d;
  logic              locked_q, rst_out_q;
  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_accept_s, cfg_bad_s;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [ACC_W-1:0]  num_q [NUM_CH];
  logic [ACC_W-1:0]  num_d [NUM_CH];
  logic [ACC_W-1:0]  den_q [NUM_CH];
  logic [ACC_W-1:0]  den_d [NUM_CH];
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W:0]    sum_s [NUM_CH];

  assign lock_s = sync2_q;

  // Lock supervisor next-state: filter counts consecutive synchronised lock cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = FILTER;
          cnt_d   = '0;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      FILTER: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_d = (state_d == RUN);

  // Config handshake decode; a request is accepted even when it is rejected
  always_comb begin
    cfg_accept_s = cfg_valid & cfg_ready_q;
    cfg_bad_s    = (cfg_den == '0) || (cfg_num > cfg_den) || (int'(cfg_ch) >= NUM_CH);
    cfg_ready_d  = ~cfg_accept_s;
    cfg_err_d    = cfg_accept_s & cfg_bad_s;
  end

  // Per-channel accumulators; leaving RUN clears acc/ce but keeps the ratio
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      num_d[i] = num_q[i];
      den_d[i] = den_q[i];
      sum_s[i] = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
      if (cfg_accept_s && !cfg_bad_s && (int'(cfg_ch) == i)) begin
        num_d[i] = cfg_num;
        den_d[i] = cfg_den;
        acc_d[i] = '0;
        ce_d[i]  = 1'b0;
      end else if (!run_d) begin
        acc_d[i] = '0;
        ce_d[i]  = 1'b0;
      end else if (sum_s[i] >= {1'b0, den_q[i]}) begin
        acc_d[i] = ACC_W'(sum_s[i] - {1'b0, den_q[i]});
        ce_d[i]  = 1'b1;
      end else begin
        acc_d[i] = sum_s[i][ACC_W-1:0];
        ce_d[i]  = 1'b0;
      end
    end
  end

  // State, synchroniser and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      rst_out_q   <= 1'b1;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      ce_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        num_q[i] <= ACC_W'(DEF_NUM);
        den_q[i] <= ACC_W'(DEF_DEN);
        acc_q[i] <= '0;
      end
    end else begin
      sync1_q     <= pll_lock;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      locked_q    <= run_d;
      rst_out_q   <= ~run_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      ce_q        <= ce_d;
      for (int i = 0; i < NUM_CH; i++) begin
        num_q[i] <= num_d[i];
        den_q[i] <= den_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign ce_out    = ce_q;
  assign locked    = locked_q;
  assign rst_out   = rst_out_q;

endmodule
